// File: rtl/cmult_sched_if.sv
// rtl/cmult_sched_if.sv - request, multiplier and result bus of the shared complex-multiplier scheduler
interface cmult_sched_if #(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 8,
    parameter int BWIDTH = 9
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = AWIDTH + BWIDTH + 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*AWIDTH-1:0] req_ar;
    logic [NREQ*AWIDTH-1:0] req_ai;
    logic [NREQ*BWIDTH-1:0] req_br;
    logic [NREQ*BWIDTH-1:0] req_bi;
    logic [AWIDTH-1:0]      mul_ar;
    logic [AWIDTH-1:0]      mul_ai;
    logic [BWIDTH-1:0]      mul_br;
    logic [BWIDTH-1:0]      mul_bi;
    logic [PW-1:0]          mul_pr;
    logic [PW-1:0]          mul_pi;
    logic                   res_valid;
    logic                   res_ready;
    logic [IDW-1:0]         res_id;
    logic [PW-1:0]          res_pr;
    logic [PW-1:0]          res_pi;
    logic                   busy;

    modport master (
        output req_valid, req_ar, req_ai, req_br, req_bi, mul_pr, mul_pi, res_ready,
        input  req_ready, mul_ar, mul_ai, mul_br, mul_bi, res_valid, res_id, res_pr, res_pi, busy
    );

    modport slave (
        input  req_valid, req_ar, req_ai, req_br, req_bi, mul_pr, mul_pi, res_ready,
        output req_ready, mul_ar, mul_ai, mul_br, mul_bi, res_valid, res_id, res_pr, res_pi, busy
    );
endinterface

// File: rtl/cmult_sched.sv
// rtl/cmult_sched.sv - round-robin scheduler sharing one pipelined complex multiplier, with credit-guarded result FIFO
module cmult_sched #(
    parameter int NREQ    = 4,
    parameter int AWIDTH  = 8,
    parameter int BWIDTH  = 9,
    parameter int LATENCY = 6,
    parameter int DEPTH   = 8,
    parameter int IDW     = $clog2(NREQ)
) (
    input logic          clk,
    input logic          rst,
    cmult_sched_if.slave bus
);
    localparam int PW = AWIDTH + BWIDTH + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = IDW + 1;

    logic [CW-1:0]     occ;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    gnt_id;
    logic              gnt_ok;
    logic [SW-1:0]     cand;
    logic [AWIDTH-1:0] ar_q, ai_q;
    logic [BWIDTH-1:0] br_q, bi_q;
    logic              tag_v  [0:LATENCY];
    logic [IDW-1:0]    tag_id [0:LATENCY];
    logic [AW-1:0]     wp, rp;
    logic [CW-1:0]     fcnt;
    logic [IDW-1:0]    mem_id [DEPTH];
    logic [PW-1:0]     mem_pr [DEPTH];
    logic [PW-1:0]     mem_pi [DEPTH];
    logic              cap, res_v, pop;

    assign cap   = tag_v[LATENCY];
    assign res_v = (fcnt != '0);
    assign pop   = res_v & bus.res_ready;

    // Credits count in-flight plus stored results, so a grant always has a FIFO slot waiting.
    always_comb begin
        gnt_ok = 1'b0;
        gnt_id = '0;
        cand   = '0;
        if (!rst && occ < CW'(DEPTH)) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr} + SW'(k);
                if (cand >= SW'(NREQ)) cand = cand - SW'(NREQ);
                if (!gnt_ok && bus.req_valid[cand[IDW-1:0]]) begin
                    gnt_ok = 1'b1;
                    gnt_id = cand[IDW-1:0];
                end
            end
        end
    end

    assign bus.req_ready = gnt_ok ? (NREQ'(1) << gnt_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= '0;
            ptr  <= '0;
            ar_q <= '0;
            ai_q <= '0;
            br_q <= '0;
            bi_q <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tag_v[s]  <= 1'b0;
                tag_id[s] <= '0;
            end
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            case ({gnt_ok, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: ;
            endcase
            if (gnt_ok) begin
                ptr  <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                ar_q <= bus.req_ar[gnt_id*AWIDTH +: AWIDTH];
                ai_q <= bus.req_ai[gnt_id*AWIDTH +: AWIDTH];
                br_q <= bus.req_br[gnt_id*BWIDTH +: BWIDTH];
                bi_q <= bus.req_bi[gnt_id*BWIDTH +: BWIDTH];
            end else begin
                ar_q <= '0;
                ai_q <= '0;
                br_q <= '0;
                bi_q <= '0;
            end
            // Stage 0 is the issue tag; stage LATENCY lines up with the multiplier output.
            tag_v[0]  <= gnt_ok;
            tag_id[0] <= gnt_id;
            for (int s = 1; s <= LATENCY; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            if (cap) wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
            if (pop) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
            case ({cap, pop})
                2'b10:   fcnt <= fcnt + CW'(1);
                2'b01:   fcnt <= fcnt - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            mem_id[wp] <= tag_id[LATENCY];
            mem_pr[wp] <= bus.mul_pr;
            mem_pi[wp] <= bus.mul_pi;
        end
    end

    assign bus.mul_ar    = ar_q;
    assign bus.mul_ai    = ai_q;
    assign bus.mul_br    = br_q;
    assign bus.mul_bi    = bi_q;
    assign bus.res_valid = res_v;
    assign bus.res_id    = res_v ? mem_id[rp] : '0;
    assign bus.res_pr    = res_v ? mem_pr[rp] : '0;
    assign bus.res_pi    = res_v ? mem_pi[rp] : '0;
    assign bus.busy      = (occ != '0);
endmodule

// File: tb/tb_cmult_sched.sv
// tb/tb_cmult_sched.sv - self-checking bench for cmult_sched with a behavioural cmult and reference model
module tb_cmult_sched;
    localparam int NREQ = 4, AW = 8, BW = 9, LAT = 6, DEPTH = 8, PW = AW + BW + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmult_sched_if #(.NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW)) bus ();

    cmult_sched #(.NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stand-in for the shared cmult: six register stages, no reset, no enable.
    logic signed [PW-1:0] xar, xai, xbr, xbi;
    logic signed [PW-1:0] pr_q [1:LAT];
    logic signed [PW-1:0] pi_q [1:LAT];
    assign xar = PW'($signed(bus.mul_ar));
    assign xai = PW'($signed(bus.mul_ai));
    assign xbr = PW'($signed(bus.mul_br));
    assign xbi = PW'($signed(bus.mul_bi));
    always_ff @(posedge clk) begin
        pr_q[1] <= xar * xbr - xai * xbi;
        pi_q[1] <= xar * xbi + xai * xbr;
        for (int s = 2; s <= LAT; s++) begin
            pr_q[s] <= pr_q[s-1];
            pi_q[s] <= pi_q[s-1];
        end
    end
    assign bus.mul_pr = pr_q[LAT];
    assign bus.mul_pi = pi_q[LAT];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct { int due; int id; int pr; int pi; } item_t;
    item_t pend[$];
    item_t fifo[$];
    int m_ptr, m_occ, m_cyc, m_gnt;
    int m_mul [4];
    int opa [NREQ][4];
    logic [NREQ-1:0] last_ready;

    task automatic model_reset();
        pend.delete();
        fifo.delete();
        m_ptr = 0;
        m_occ = 0;
        m_cyc = 0;
        m_mul = '{0, 0, 0, 0};
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ar[i*AW +: AW] = AW'(opa[i][0]);
            bus.req_ai[i*AW +: AW] = AW'(opa[i][1]);
            bus.req_br[i*BW +: BW] = BW'(opa[i][2]);
            bus.req_bi[i*BW +: BW] = BW'(opa[i][3]);
        end
    endtask

    task automatic rand_ops(input int i);
        opa[i][0] = int'($urandom_range(0, 255)) - 128;
        opa[i][1] = int'($urandom_range(0, 255)) - 128;
        opa[i][2] = int'($urandom_range(0, 511)) - 256;
        opa[i][3] = int'($urandom_range(0, 511)) - 256;
    endtask

    function automatic int oh2id(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock cycle: compare against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        bit pop;
        int a, b, c, d;
        drive_ops();
        #1;
        m_gnt = -1;
        if (!rst && m_occ < DEPTH)
            for (int k = 0; k < NREQ; k++)
                if (m_gnt < 0 && bus.req_valid[(m_ptr + k) % NREQ]) m_gnt = (m_ptr + k) % NREQ;
        last_ready = bus.req_ready;
        chk("req_ready", bus.req_ready, m_gnt >= 0 ? (1 << m_gnt) : 0);
        chk("res_valid", bus.res_valid, fifo.size() > 0);
        chk("res_id", bus.res_id, fifo.size() > 0 ? fifo[0].id : 0);
        chk("res_pr", $signed(bus.res_pr), fifo.size() > 0 ? fifo[0].pr : 0);
        chk("res_pi", $signed(bus.res_pi), fifo.size() > 0 ? fifo[0].pi : 0);
        chk("busy", bus.busy, m_occ != 0);
        chk("mul_ar", $signed(bus.mul_ar), m_mul[0]);
        chk("mul_ai", $signed(bus.mul_ai), m_mul[1]);
        chk("mul_br", $signed(bus.mul_br), m_mul[2]);
        chk("mul_bi", $signed(bus.mul_bi), m_mul[3]);
        pop = (fifo.size() > 0) && bus.res_ready;
        @(posedge clk);
        m_cyc++;
        if (pop) void'(fifo.pop_front());
        while (pend.size() > 0 && pend[0].due == m_cyc) fifo.push_back(pend.pop_front());
        m_occ += int'(m_gnt >= 0) - int'(pop);
        if (m_gnt >= 0) begin
            a = opa[m_gnt][0]; b = opa[m_gnt][1]; c = opa[m_gnt][2]; d = opa[m_gnt][3];
            pend.push_back('{m_cyc + LAT + 1, m_gnt, a * c - b * d, a * d + b * c});
            m_ptr = (m_gnt + 1) % NREQ;
            m_mul = opa[m_gnt];
        end else begin
            m_mul = '{0, 0, 0, 0};
        end
        @(negedge clk);
    endtask

    always @(posedge clk)
        if (!rst && dut.cap) chk("fifo_full_at_write", dut.fcnt == DEPTH, 0);

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    typedef struct { int id; int ar; int ai; int br; int bi; int pr; int pi; } vec_t;
    vec_t vecs [5];
    int exp_wrap [4];
    int lat, ng, prev, g, first_pop, first_gnt;

    initial begin
        vecs[0] = '{1, 3, -2, 5, 4, 23, 2};
        vecs[1] = '{0, -128, -128, -256, -256, 0, 65536};
        vecs[2] = '{3, 127, 127, 255, -256, 64897, -127};
        vecs[3] = '{2, -128, 127, 255, 255, -65025, -255};
        vecs[4] = '{1, 0, 5, -7, 0, 0, -35};
        exp_wrap = '{3, 2, 3, 2};
        for (int i = 0; i < NREQ; i++) opa[i] = '{0, 0, 0, 0};
        drive_ops();
        bus.req_valid = '1;
        bus.res_ready = 1'b0;
        model_reset();

        #1 rst = 1'b1;
        #2;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_pr", bus.res_pr, 0);
        chk("rst_mul_ar", bus.mul_ar, 0);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            opa[vecs[v].id] = '{vecs[v].ar, vecs[v].ai, vecs[v].br, vecs[v].bi};
            bus.req_valid = NREQ'(1) << vecs[v].id;
            bus.res_ready = 1'b0;
            step();
            chk("vec_ready", last_ready, 1 << vecs[v].id);
            bus.req_valid = '0;
            lat = 0;
            while (!bus.res_valid && lat < 20) begin
                step();
                lat++;
            end
            chk("vec_latency", lat, LAT + 1);
            chk("vec_id", bus.res_id, vecs[v].id);
            chk("vec_pr", $signed(bus.res_pr), vecs[v].pr);
            chk("vec_pi", $signed(bus.res_pi), vecs[v].pi);
            bus.res_ready = 1'b1;
            step();
            bus.res_ready = 1'b0;
            chk("vec_busy_after_pop", bus.busy, 0);
        end

        for (int i = 0; i < NREQ; i++) rand_ops(i);
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        prev = -1;
        for (int t = 0; t < 30; t++) begin
            step();
            g = oh2id(last_ready);
            if (g >= 0) begin
                if (prev >= 0) chk("rr_order", g, (prev + 1) % NREQ);
                prev = g;
            end
        end
        bus.req_valid = '0;
        for (int t = 0; t < 12; t++) step();

        rand_ops(0);
        bus.req_valid = 4'b0001;
        bus.res_ready = 1'b0;
        ng = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (last_ready != 0) ng++;
        end
        chk("bp_accepts", ng, DEPTH);
        chk("bp_busy", bus.busy, 1);
        chk("bp_ready_low", bus.req_ready, 0);
        bus.res_ready = 1'b1;
        first_pop = -1;
        first_gnt = -1;
        for (int t = 0; t < 25; t++) begin
            if (first_pop < 0 && bus.res_valid) first_pop = t;
            step();
            if (first_gnt < 0 && last_ready != 0) first_gnt = t;
        end
        chk("bp_resume", first_gnt - first_pop, 1);
        bus.req_valid = '0;
        for (int t = 0; t < 16; t++) step();

        rand_ops(2);
        rand_ops(3);
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b1100;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("wrap_order", oh2id(last_ready), exp_wrap[t]);
        end
        bus.req_valid = '0;
        for (int t = 0; t < 12; t++) step();

        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < NREQ; i++) rand_ops(i);
            bus.req_valid = NREQ'($urandom);
            bus.res_ready = ($urandom % 10) < 7;
            step();
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int t = 0; t < 20; t++) step();

        for (int i = 0; i < NREQ; i++) rand_ops(i);
        bus.req_valid = '1;
        bus.res_ready = 1'b0;
        for (int t = 0; t < 3; t++) step();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", bus.req_ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_mul_ar", bus.mul_ar, 0);
        chk("mid_rst_mul_bi", bus.mul_bi, 0);
        model_reset();
        bus.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        opa[2] = '{3, -2, 5, 4};
        bus.req_valid = 4'b0100;
        step();
        chk("post_rst_grant", last_ready, 4);
        bus.req_valid = '0;
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("post_rst_latency", lat, LAT + 1);
        chk("post_rst_id", bus.res_id, 2);
        chk("post_rst_pr", $signed(bus.res_pr), 23);
        chk("post_rst_pi", $signed(bus.res_pi), 2);
        bus.res_ready = 1'b1;
        for (int t = 0; t < 10; t++) step();
        chk("post_rst_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
